// File: rtl/act_pingpong_mem_if.sv
// act_pingpong_mem_if
// Bundles the write, read, swap and status signals of the ping-pong
// activation memory so the block and its users share one port.
//   wr_en, wr_entry, wr_y, wr_x, wr_data : write request and address/word
//   rd_en, rd_entry, rd_y, rd_x           : read request and address
//   swap                                  : exchange write and read banks
//   rd_data, rd_valid, rd_err             : registered read response
//   wr_bank, fill_cnt, full               : bank selection and fill status
// The master modport drives requests; the slave modport is the memory.
interface act_pingpong_mem_if #(
  parameter int ENTRY_NUM = 1,
  parameter int DIM       = 1,
  parameter int DATA_SIZE = 64
);
  localparam int EW  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int DW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CAP = ENTRY_NUM * DIM * DIM;
  localparam int FW  = ($clog2(CAP + 1) > 1) ? $clog2(CAP + 1) : 1;

  logic                 wr_en;
  logic [EW-1:0]        wr_entry;
  logic [DW-1:0]        wr_y;
  logic [DW-1:0]        wr_x;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 rd_en;
  logic [EW-1:0]        rd_entry;
  logic [DW-1:0]        rd_y;
  logic [DW-1:0]        rd_x;
  logic                 swap;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_err;
  logic                 wr_bank;
  logic [FW-1:0]        fill_cnt;
  logic                 full;

  modport master (
    output wr_en, wr_entry, wr_y, wr_x, wr_data,
    output rd_en, rd_entry, rd_y, rd_x, swap,
    input  rd_data, rd_valid, rd_err, wr_bank, fill_cnt, full
  );

  modport slave (
    input  wr_en, wr_entry, wr_y, wr_x, wr_data,
    input  rd_en, rd_entry, rd_y, rd_x, swap,
    output rd_data, rd_valid, rd_err, wr_bank, fill_cnt, full
  );
endinterface

// File: rtl/act_pingpong_mem.sv
// act_pingpong_mem
// Double-buffered activation map store. One bank is filled by writes while
// the other is read; swap exchanges their roles. Each bank holds ENTRY_NUM
// square DIM x DIM maps of DATA_SIZE-bit words.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset (storage is not cleared)
//   bus  : act_pingpong_mem_if slave modport (requests in, read result and
//          fill status out)
module act_pingpong_mem #(
  parameter     NAME      = "DEFAULT ACT MEM",
  parameter int ENTRY_NUM = 1,
  parameter int DIM       = 1,
  parameter int DATA_SIZE = 64
) (
  input logic               clk,
  input logic               rst,
  act_pingpong_mem_if.slave bus
);
  localparam int EW  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int DW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CAP = ENTRY_NUM * DIM * DIM;
  localparam int AW  = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int FW  = ($clog2(CAP + 1) > 1) ? $clog2(CAP + 1) : 1;

  // One extra bit so the limits themselves are representable.
  localparam logic [EW:0]   ENTRY_LIM = (EW + 1)'(ENTRY_NUM);
  localparam logic [DW:0]   DIM_LIM   = (DW + 1)'(DIM);
  localparam logic [FW-1:0] CAP_F     = FW'(CAP);

  // The label only identifies the instance; this empty block keeps it referenced.
  if ($bits(NAME) == 0) begin : g_unlabelled
  end

  function automatic logic [AW-1:0] lin_addr(input logic [EW-1:0] e,
                                             input logic [DW-1:0] y,
                                             input logic [DW-1:0] x);
    int a;
    a = (int'(e) * DIM + int'(y)) * DIM + int'(x);
    return AW'(a);
  endfunction

  logic [DATA_SIZE-1:0] mem_q [2][CAP];

  logic                 wr_bank_q, wr_bank_d;
  logic [FW-1:0]        fill_cnt_q, fill_cnt_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_err_q, rd_err_d;

  logic          wr_ok;
  logic          rd_in_range;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_bank;

  always_comb begin
    wr_ok = bus.wr_en
            && ({1'b0, bus.wr_entry} < ENTRY_LIM)
            && ({1'b0, bus.wr_y} < DIM_LIM)
            && ({1'b0, bus.wr_x} < DIM_LIM);
    rd_in_range = ({1'b0, bus.rd_entry} < ENTRY_LIM)
                  && ({1'b0, bus.rd_y} < DIM_LIM)
                  && ({1'b0, bus.rd_x} < DIM_LIM);
    wr_addr = lin_addr(bus.wr_entry, bus.wr_y, bus.wr_x);
    rd_addr = lin_addr(bus.rd_entry, bus.rd_y, bus.rd_x);
    rd_bank = ~wr_bank_q;
  end

  // Swap wins over the fill increment: a write accepted on the swap edge
  // belongs to the old bank and must not count toward the new one.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    fill_cnt_d = fill_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;

    if (bus.swap) begin
      wr_bank_d  = ~wr_bank_q;
      fill_cnt_d = '0;
    end else if (wr_ok && (fill_cnt_q != CAP_F)) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end

    // Read uses the pre-swap read bank; rd_data holds when idle.
    if (bus.rd_en) begin
      rd_valid_d = 1'b1;
      if (rd_in_range) begin
        rd_data_d = mem_q[rd_bank][rd_addr];
      end else begin
        rd_err_d  = 1'b1;
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      fill_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      fill_cnt_q <= fill_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Storage has no reset; a write presented during reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_bank_q][wr_addr] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_bank  = wr_bank_q;
  assign bus.fill_cnt = fill_cnt_q;
  assign bus.full     = (fill_cnt_q == CAP_F);
endmodule
